// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, ALU functions, branch/move
// conditions, status codes, register IDs and condition-code bit positions.
package y86_pkg;

  localparam logic [3:0] IcodeHalt   = 4'h0;
  localparam logic [3:0] IcodeNop    = 4'h1;
  localparam logic [3:0] IcodeRrmovq = 4'h2;
  localparam logic [3:0] IcodeIrmovq = 4'h3;
  localparam logic [3:0] IcodeRmmovq = 4'h4;
  localparam logic [3:0] IcodeMrmovq = 4'h5;
  localparam logic [3:0] IcodeOpq    = 4'h6;
  localparam logic [3:0] IcodeJxx    = 4'h7;
  localparam logic [3:0] IcodeCall   = 4'h8;
  localparam logic [3:0] IcodeRet    = 4'h9;
  localparam logic [3:0] IcodePushq  = 4'hA;
  localparam logic [3:0] IcodePopq   = 4'hB;

  typedef enum logic [1:0] {
    AluAdd = 2'd0,
    AluSub = 2'd1,
    AluAnd = 2'd2,
    AluXor = 2'd3
  } alu_fun_e;

  localparam logic [3:0] CondAlways = 4'h0;
  localparam logic [3:0] CondLe     = 4'h1;
  localparam logic [3:0] CondL      = 4'h2;
  localparam logic [3:0] CondE      = 4'h3;
  localparam logic [3:0] CondNe     = 4'h4;
  localparam logic [3:0] CondGe     = 4'h5;
  localparam logic [3:0] CondG      = 4'h6;

  localparam logic [3:0] StatAok = 4'h1;
  localparam logic [3:0] StatHlt = 4'h2;
  localparam logic [3:0] StatAdr = 4'h3;
  localparam logic [3:0] StatIns = 4'h4;

  localparam logic [3:0] RegNone = 4'hF;

  // cc is packed as {ZF, SF, OF}
  localparam int unsigned CcZf = 2;
  localparam int unsigned CcSf = 1;
  localparam int unsigned CcOf = 0;

endpackage

// File: rtl/alu_64.sv
// Two's-complement ALU (add/sub/and/xor) with zero, sign and overflow flags.
module alu_64
  import y86_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_fun_e         fun,
  output logic [WIDTH-1:0] result,
  output logic             zf,
  output logic             sf,
  output logic             of
);

  always_comb begin
    result = b + a;
    of     = 1'b0;
    unique case (fun)
      AluAdd: begin
        result = b + a;
        of     = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      end
      AluSub: begin
        result = b - a;
        of     = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != b[WIDTH-1]);
      end
      AluAnd: result = b & a;
      AluXor: result = b ^ a;
      default: result = b + a;
    endcase
    zf = (result == '0);
    sf = result[WIDTH-1];
  end

endmodule

// File: rtl/execute_stage.sv
// Y86-64 Execute stage: operand selection, ALU, condition codes, Cnd
// evaluation and the E/M pipeline register feeding the Memory stage.
module execute_stage
  import y86_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter logic [3:0]  RNONE = RegNone
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       E_stat,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_ifun,
  input  logic [WIDTH-1:0] E_valA,
  input  logic [WIDTH-1:0] E_valB,
  input  logic [WIDTH-1:0] E_valC,
  input  logic [3:0]       E_dstE,
  input  logic [3:0]       E_dstM,
  input  logic             m_exc,
  input  logic             W_exc,
  input  logic             M_bubble,
  output logic [WIDTH-1:0] e_valE,
  output logic [3:0]       e_dstE,
  output logic             e_Cnd,
  output logic [3:0]       M_stat,
  output logic [3:0]       M_icode,
  output logic             M_Cnd,
  output logic [WIDTH-1:0] M_valE,
  output logic [WIDTH-1:0] M_valA,
  output logic [3:0]       M_dstE,
  output logic [3:0]       M_dstM,
  output logic [2:0]       cc
);

  localparam logic [WIDTH-1:0] StackDec = ~WIDTH'(7);  // -8
  localparam logic [WIDTH-1:0] StackInc = WIDTH'(8);

  logic [WIDTH-1:0] alu_a, alu_b;
  alu_fun_e         alu_fun;
  logic             new_zf, new_sf, new_of;
  logic             set_cc;
  logic             zf, sf, of;

  always_comb begin
    case (E_icode)
      IcodeRrmovq, IcodeOpq:                   alu_a = E_valA;
      IcodeIrmovq, IcodeRmmovq, IcodeMrmovq:   alu_a = E_valC;
      IcodeCall, IcodePushq:                   alu_a = StackDec;
      IcodeRet, IcodePopq:                     alu_a = StackInc;
      default:                                 alu_a = '0;
    endcase
  end

  always_comb begin
    case (E_icode)
      IcodeRmmovq, IcodeMrmovq, IcodeOpq, IcodeCall,
      IcodePushq, IcodeRet, IcodePopq:         alu_b = E_valB;
      default:                                 alu_b = '0;
    endcase
  end

  assign alu_fun = (E_icode == IcodeOpq) ? alu_fun_e'(E_ifun[1:0]) : AluAdd;

  alu_64 #(
    .WIDTH(WIDTH)
  ) u_alu (
    .a     (alu_a),
    .b     (alu_b),
    .fun   (alu_fun),
    .result(e_valE),
    .zf    (new_zf),
    .sf    (new_sf),
    .of    (new_of)
  );

  assign set_cc = (E_icode == IcodeOpq) && !m_exc && !W_exc;

  // Cnd uses the flags as they stand before this instruction's own update
  assign zf = cc[CcZf];
  assign sf = cc[CcSf];
  assign of = cc[CcOf];

  always_comb begin
    case (E_ifun)
      CondAlways: e_Cnd = 1'b1;
      CondLe:     e_Cnd = (sf ^ of) | zf;
      CondL:      e_Cnd = sf ^ of;
      CondE:      e_Cnd = zf;
      CondNe:     e_Cnd = !zf;
      CondGe:     e_Cnd = !(sf ^ of);
      CondG:      e_Cnd = !(sf ^ of) & !zf;
      default:    e_Cnd = 1'b0;
    endcase
  end

  assign e_dstE = ((E_icode == IcodeRrmovq) && !e_Cnd) ? RNONE : E_dstE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cc <= 3'b100;
    end else if (set_cc) begin
      cc <= {new_zf, new_sf, new_of};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      M_stat  <= StatAok;
      M_icode <= IcodeNop;
      M_Cnd   <= 1'b0;
      M_valE  <= '0;
      M_valA  <= '0;
      M_dstE  <= RNONE;
      M_dstM  <= RNONE;
    end else if (M_bubble) begin
      M_stat  <= StatAok;
      M_icode <= IcodeNop;
      M_Cnd   <= 1'b0;
      M_valE  <= '0;
      M_valA  <= '0;
      M_dstE  <= RNONE;
      M_dstM  <= RNONE;
    end else begin
      M_stat  <= E_stat;
      M_icode <= E_icode;
      M_Cnd   <= e_Cnd;
      M_valE  <= e_valE;
      M_valA  <= E_valA;
      M_dstE  <= e_dstE;
      M_dstM  <= E_dstM;
    end
  end

endmodule

// File: doc/execute_stage.md
# execute_stage

Y86-64 pipelined Execute stage. Takes the decoded instruction from the D/E pipeline register and selects ALU operands. Computes valE with the 64-bit ALU (add/sub/and/xor), maintains the condition-code register and evaluates Cnd for cmovXX/jXX. Registers the results into the E/M pipeline register that feeds the Memory stage, and exposes combinational e_valE/e_dstE for decode forwarding.

## Interface

Parameters:
- WIDTH, 64, datapath width
- RNONE, 4'hF, "no register" destination ID

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-high
- E_stat  input  4  status of instruction in E
- E_icode / E_ifun  input  4 / 4  instruction code / function
- E_valA, E_valB, E_valC  input  64 each  operands from D/E register
- E_dstE, E_dstM  input  4 each  destination register IDs
- m_exc  input  1  instruction in M has stat ∈ {ADR, INS, HLT}
- W_exc  input  1  instruction in W has stat ∈ {ADR, INS, HLT}
- M_bubble  input  1  load NOP bubble into E/M next edge
- e_valE  output  64  combinational ALU result (forwarding)
- e_dstE  output  4  combinational effective dstE (forwarding)
- e_Cnd  output  1  combinational condition result (to branch-mispredict logic)
- M_stat, M_icode  output  4 / 4  registered
- M_Cnd  output  1  registered
- M_valE, M_valA  output  64 / 64  registered
- M_dstE, M_dstM  output  4 / 4  registered
- cc  output  3  {ZF, SF, OF} register

## Operation

- Opcodes: HALT 0, NOP 1, RRMOVQ/CMOVXX 2, IRMOVQ 3, RMMOVQ 4, MRMOVQ 5, OPQ 6, JXX 7, CALL 8, RET 9, PUSHQ A, POPQ B.
- Stat: AOK 1, HLT 2, ADR 3, INS 4.
- aluA:
  - E_valA for RRMOVQ and OPQ.
  - E_valC for IRMOVQ, RMMOVQ and MRMOVQ.
  - −8 for CALL and PUSHQ.
  - +8 for RET and POPQ.
  - 0 otherwise.
- aluB:
  - E_valB for RMMOVQ, MRMOVQ, OPQ, CALL, PUSHQ, RET and POPQ.
  - 0 for RRMOVQ and IRMOVQ.
- ALU function:
  - For OPQ, taken from E_ifun: 0 add (B+A), 1 sub (B−A), 2 and, 3 xor.
  - All other icodes use add.
  - Arithmetic is two's-complement mod 2^64; carry-out is discarded.
- Flags, computed from result t:
  - ZF = (t == 0).
  - SF = t[63].
  - add: OF = (A[63]==B[63]) && (t[63]!=A[63]).
  - sub: OF = (A[63]!=B[63]) && (t[63]!=B[63]).
  - and/xor: OF = 0.
- set_cc = (E_icode == OPQ) && !m_exc && !W_exc. The cc register loads the new flags on the edge when set_cc is high; otherwise it holds.
- Cnd is evaluated from the current cc, i.e. before any update by the instruction in E. By E_ifun:
  - 0: 1
  - 1 le: (SF^OF)|ZF
  - 2 l: SF^OF
  - 3 e: ZF
  - 4 ne: !ZF
  - 5 ge: !(SF^OF)
  - 6 g: !(SF^OF)&!ZF
  - ifun > 6: Cnd = 0.
- e_dstE = RNONE when E_icode == RRMOVQ && !Cnd; otherwise E_dstE. An unconditional rrmovq (ifun 0) always writes.
- E/M register:
  - With M_bubble = 0, every edge captures stat, icode, Cnd, e_valE, E_valA, e_dstE and E_dstM.
  - With M_bubble = 1: M_stat = AOK, M_icode = NOP, M_Cnd = 0, M_valE = M_valA = 0, M_dstE = M_dstM = RNONE.
- Non-AOK E_stat passes through unchanged. Its ALU result is still registered, but it never sets cc unless it is an OPQ with no downstream exception.

## Timing

- Latency: 1 cycle from E_* inputs to M_* outputs. e_valE, e_dstE and e_Cnd are combinational in the same cycle.
- The cc update and the E/M capture happen on the same rising edge. The next instruction entering E sees the updated cc.
- Reset (asynchronous, immediate):
  - E/M register takes its bubble values: stat AOK, icode NOP, Cnd 0, valE 0, valA 0, dstE RNONE, dstM RNONE.
  - cc = {ZF=1, SF=0, OF=0}.
- Reset asserted mid-operation discards the in-flight E/M contents and cc. The first edge after deassertion captures normally.
- M_bubble and an exception in the same cycle: the bubble wins for E/M, and cc is suppressed by m_exc/W_exc independently.
- Back-to-back OPQs each update cc on successive edges. A jXX directly behind an OPQ evaluates on the cc written by that OPQ.

## Structure

- Shared package y86_pkg holds:
  - icode constants, ALU function codes, condition codes (ifun 0–6) and stat codes
  - RNONE
  - cc bit indices
- Sub-module alu_64 wraps the existing 64-bit add/sub/and/xor blocks and produces {result, ZF, SF, OF}.
- execute_stage contains:
  - operand muxes
  - the cc register
  - cond evaluation
  - the E/M register

## Test plan

- OPQ add: A = 0x7FFF_FFFF_FFFF_FFFF, B = 1 → M_valE = 0x8000_0000_0000_0000 next cycle; cc = {ZF0, SF1, OF1}.
- OPQ sub: A = 5, B = 5 → valE = 0, cc = {ZF1, SF0, OF0}. Following jXX ifun 3 (e) → e_Cnd = 1; ifun 4 (ne) → e_Cnd = 0.
- CMOVL (ifun 2) with cc = {0,0,0}, E_dstE = 3 → e_dstE = M_dstE = 0xF. Repeat with SF = 1 → dstE = 3, M_valE = E_valA.
- PUSHQ with valB = 0x100 → valE = 0xF8. POPQ with valB = 0x100 → valE = 0x108. Neither changes cc.
- OPQ xor with m_exc = 1 → cc unchanged, M_valE still captured. M_bubble = 1 → M_icode = NOP, M_dstE = M_dstM = 0xF.
- Assert rst asynchronously mid-stream (between edges) → M_icode = 1, M_stat = 1 and cc = 3'b100 immediately, with no clock edge required.
